adc_power_sequencer: RTL
========================

// Module: adc_power_sequencer
// PURPOSE
//   Sequences ADC front-end bring-up and tear-down: supply, reference, IO/amplifier enables,
//   ADC reset release, optional init command on the ADC AXIS command stream, then DMA and
//   packetizer reset release. Sits between the AXI-Lite config register block (drives en)
//   and the ADC, DMA and packetizer. Guarantees ordering and settling delays that software
//   cannot time reliably.
// PARAMETERS
//   DELAY_W     24            width of the settling counter
//   PWR_DELAY   24'd100000    cycles in PWR after pwr_en rises (0 treated as 1)
//   REF_DELAY   24'd50000     cycles in REF after ref_en rises (0 treated as 1)
//   AMP_DELAY   24'd10000     cycles in AMP after io/diffamp/opamp enables rise (0 treated as 1)
//   RST_HOLD    24'd16        cycles in RST, adc_resetn still low, before release (0 treated as 1)
//   DOWN_DELAY  24'd1000      cycles in DOWN before ref_en/pwr_en drop (0 treated as 1)
//   INIT_WORD   32'h0000_0000 command word sent to the ADC after reset release
// PORTS
//   aclk               in   1   clock
//   aresetn            in   1   async active-low reset
//   en                 in   1   level request: 1 = bring up / stay up, 0 = tear down
//   pwr_en             out  1   supply enable
//   ref_en             out  1   reference enable
//   io_en              out  1   IO enable
//   diffamp_en         out  1   differential amplifier enable
//   opamp_en           out  1   op-amp enable
//   adc_resetn         out  1   ADC reset, active-low
//   dma_resetn         out  1   DMA reset, active-low
//   packetizer_resetn  out  1   packetizer reset, active-low
//   m_axis_tdata       out  32  ADC command word
//   m_axis_tvalid      out  1   command valid
//   m_axis_tready      in   1   command accepted
//   ready              out  1   1 only in RUN
//   busy               out  1   1 in every state except OFF and RUN
//   state              out  3   current state encoding, for the status register
// BEHAVIOUR
//   - Reset: every output = 0; state = OFF. Asserting aresetn mid-operation aborts
//     immediately and asynchronously. No output glitches high.
//   - All outputs are registered.
//   - States (encoding): OFF=0, PWR=1, REF=2, AMP=3, RST=4, INIT=5, RUN=6, DOWN=7.
//   - Timed states PWR, REF, AMP, RST and DOWN load the counter with max(DELAY,1)-1 on entry.
//     Each exits on the cycle the counter is 0, so it lasts exactly max(DELAY,1) cycles.
//   - OFF: en=1 -> PWR.
//   - PWR: pwr_en=1 -> REF.
//   - REF: ref_en=1 -> AMP.
//   - AMP: io_en, diffamp_en, opamp_en all =1 -> RST.
//   - RST: timer expiry -> INIT. adc_resetn rises on entry to INIT.
//   - INIT: m_axis_tvalid=1 with m_axis_tdata=INIT_WORD, both held stable until tready.
//     On the handshake cycle, tvalid drops next cycle and state -> RUN.
//   - RUN: dma_resetn=1, packetizer_resetn=1, ready=1.
//   - en=0 in PWR, REF, AMP, RST or RUN -> DOWN next cycle.
//   - en=0 in INIT is deferred until the handshake completes (AXIS valid never retracted),
//     then -> DOWN instead of RUN.
//   - DOWN entry, same edge: adc_resetn, dma_resetn, packetizer_resetn, io_en, diffamp_en and
//     opamp_en all go to 0. ref_en/pwr_en keep their current values.
//     On timer expiry: ref_en=0, pwr_en=0, -> OFF.
//   - DOWN always completes to OFF regardless of en. en=1 seen in OFF restarts from PWR.
//   - Enables only change at state transitions. Enables never rise out of order
//     pwr -> ref -> amps -> adc -> dma/packetizer.
//   - m_axis_tdata = INIT_WORD constantly. m_axis_tvalid=0 outside INIT.
// CONFIGURATION
//   ADC_SEQ_INIT_CMD_EN defined:
//     INIT state and AXIS handshake as above.
//   ADC_SEQ_INIT_CMD_EN undefined:
//     - RST expiry goes directly to RUN; adc_resetn, dma_resetn and packetizer_resetn rise
//       on the same edge.
//     - m_axis_tvalid tied 0; m_axis_tready ignored; INIT encoding unused.
// TESTING (PWR_DELAY=4, REF_DELAY=3, AMP_DELAY=2, RST_HOLD=2, DOWN_DELAY=3, INIT_WORD=32'hA5A5_0001)
//   1. en 0->1, tready=1 ->
//      - pwr_en rises 1 cycle after en is sampled.
//      - ref_en 4 cycles later; io/diffamp/opamp 3 later; adc_resetn 4 later.
//      - One beat of 32'hA5A5_0001.
//      - dma/packetizer resetn and ready rise 1 cycle after the handshake; busy=0.
//   2. tready held 0 for 5 cycles in INIT ->
//      - tvalid=1 and tdata stable all 5 cycles; ready=0.
//      - tready=1 -> RUN next cycle.
//   3. en 1->0 during REF (ref_en=1) ->
//      - Next edge: amps/io/resets 0, state=7.
//      - 3 cycles later ref_en=pwr_en=0, state=0.
//   4. en 0 then back to 1 on the first DOWN cycle ->
//      - DOWN runs its full 3 cycles to OFF.
//      - Then restarts at PWR, repeating the test-1 timing.
//   5. aresetn low mid-RUN -> all outputs 0 without a clock edge.
//      Release with en=1 -> full sequence from PWR.
//   6. ADC_SEQ_INIT_CMD_EN undefined ->
//      - adc_resetn, dma_resetn, packetizer_resetn rise together 2 cycles after RST entry.
//      - m_axis_tvalid never 1.

Source files
------------

// File: rtl/adc_power_sequencer.sv
// ADC front-end power/reset sequencer: ordered bring-up and tear-down with settling timers.
// Optional init command on the AXIS stream: define ADC_SEQ_INIT_CMD_EN.
`timescale 1ns/1ps
module adc_power_sequencer #(
  parameter int unsigned         DELAY_W    = 24,
  parameter logic [DELAY_W-1:0]  PWR_DELAY  = 24'd100000,
  parameter logic [DELAY_W-1:0]  REF_DELAY  = 24'd50000,
  parameter logic [DELAY_W-1:0]  AMP_DELAY  = 24'd10000,
  parameter logic [DELAY_W-1:0]  RST_HOLD   = 24'd16,
  parameter logic [DELAY_W-1:0]  DOWN_DELAY = 24'd1000,
  parameter logic [31:0]         INIT_WORD  = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        en,
  output logic        pwr_en,
  output logic        ref_en,
  output logic        io_en,
  output logic        diffamp_en,
  output logic        opamp_en,
  output logic        adc_resetn,
  output logic        dma_resetn,
  output logic        packetizer_resetn,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        ready,
  output logic        busy,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_PWR  = 3'd1,
    S_REF  = 3'd2,
    S_AMP  = 3'd3,
    S_RST  = 3'd4,
    S_INIT = 3'd5,
    S_RUN  = 3'd6,
    S_DOWN = 3'd7
  } state_t;

  localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);

  // A zero delay still spends one cycle in the state.
  function automatic logic [DELAY_W-1:0] ld_val(
    input logic [DELAY_W-1:0] d
  );
    return (d == '0) ? '0 : d - ONE;
  endfunction

  state_t             st, st_nxt;
  logic [DELAY_W-1:0] cnt, cnt_nxt;
  logic [DELAY_W-1:0] cnt_ld;
  logic               done;
  logic               go_down;
  logic pwr_n, ref_n, amp_n, adc_n, dp_n, tv_n;

`ifndef ADC_SEQ_INIT_CMD_EN
  logic unused_tready;
  assign unused_tready = m_axis_tready;
`endif

  assign done  = (cnt == '0);
  assign state = st;

  // Next state and next output values; enables only move on transitions.
  always_comb begin
    st_nxt  = st;
    pwr_n   = pwr_en;
    ref_n   = ref_en;
    amp_n   = io_en;
    adc_n   = adc_resetn;
    dp_n    = dma_resetn;
    tv_n    = m_axis_tvalid;
    go_down = 1'b0;
    unique case (st)
      S_OFF: begin
        if (en) begin
          st_nxt = S_PWR;
          pwr_n  = 1'b1;
        end
      end
      S_PWR: begin
        if (!en) go_down = 1'b1;
        else if (done) begin
          st_nxt = S_REF;
          ref_n  = 1'b1;
        end
      end
      S_REF: begin
        if (!en) go_down = 1'b1;
        else if (done) begin
          st_nxt = S_AMP;
          amp_n  = 1'b1;
        end
      end
      S_AMP: begin
        if (!en) go_down = 1'b1;
        else if (done) st_nxt = S_RST;
      end
      S_RST: begin
        if (!en) go_down = 1'b1;
        else if (done) begin
`ifdef ADC_SEQ_INIT_CMD_EN
          st_nxt = S_INIT;
          adc_n  = 1'b1;
          tv_n   = 1'b1;
`else
          st_nxt = S_RUN;
          adc_n  = 1'b1;
          dp_n   = 1'b1;
`endif
        end
      end
`ifdef ADC_SEQ_INIT_CMD_EN
      S_INIT: begin
        // A pending drop waits for the beat so valid is never retracted.
        if (m_axis_tready) begin
          tv_n = 1'b0;
          if (en) begin
            st_nxt = S_RUN;
            dp_n   = 1'b1;
          end else begin
            go_down = 1'b1;
          end
        end
      end
`endif
      S_RUN: begin
        if (!en) go_down = 1'b1;
      end
      S_DOWN: begin
        if (done) begin
          st_nxt = S_OFF;
          pwr_n  = 1'b0;
          ref_n  = 1'b0;
        end
      end
      default: st_nxt = S_OFF;
    endcase
    if (go_down) begin
      st_nxt = S_DOWN;
      amp_n  = 1'b0;
      adc_n  = 1'b0;
      dp_n   = 1'b0;
    end
  end

  // Settling counter reload value for the state being entered.
  always_comb begin
    cnt_ld = '0;
    unique case (st_nxt)
      S_PWR:   cnt_ld = ld_val(PWR_DELAY);
      S_REF:   cnt_ld = ld_val(REF_DELAY);
      S_AMP:   cnt_ld = ld_val(AMP_DELAY);
      S_RST:   cnt_ld = ld_val(RST_HOLD);
      S_DOWN:  cnt_ld = ld_val(DOWN_DELAY);
      default: cnt_ld = '0;
    endcase
    if (st_nxt != st)  cnt_nxt = cnt_ld;
    else if (!done)    cnt_nxt = cnt - ONE;
    else               cnt_nxt = cnt;
  end

  // State, counter and all outputs are registered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st                <= S_OFF;
      cnt               <= '0;
      pwr_en            <= 1'b0;
      ref_en            <= 1'b0;
      io_en             <= 1'b0;
      diffamp_en        <= 1'b0;
      opamp_en          <= 1'b0;
      adc_resetn        <= 1'b0;
      dma_resetn        <= 1'b0;
      packetizer_resetn <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      ready             <= 1'b0;
      busy              <= 1'b0;
    end else begin
      st                <= st_nxt;
      cnt               <= cnt_nxt;
      pwr_en            <= pwr_n;
      ref_en            <= ref_n;
      io_en             <= amp_n;
      diffamp_en        <= amp_n;
      opamp_en          <= amp_n;
      adc_resetn        <= adc_n;
      dma_resetn        <= dp_n;
      packetizer_resetn <= dp_n;
      m_axis_tdata      <= INIT_WORD;
      m_axis_tvalid     <= tv_n;
      ready             <= (st_nxt == S_RUN);
      busy              <= !((st_nxt == S_OFF) || (st_nxt == S_RUN));
    end
  end

endmodule
